// File: rtl/Purple_Jade_pkg.sv
// Purple_Jade_pkg: sizing constants, tag/pointer/count types, FSM state enum and the
// circular-pointer helper shared by the rename free-list controller and its storage.
package Purple_Jade_pkg;

    localparam int unsigned NUM_PHYS_REGS = 64;
    localparam int unsigned NUM_ARCH_REGS = 16;
    localparam int unsigned FREE_DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned PREG_WIDTH    = $clog2(NUM_PHYS_REGS);
    localparam int unsigned PTR_WIDTH     = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
    localparam int unsigned CNT_WIDTH     = $clog2(FREE_DEPTH + 1);

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [PTR_WIDTH-1:0]  ptr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StRecover
    } fl_state_e;

    // Advance a list pointer; depth need not be a power of two, so wrap explicitly.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FREE_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/free_list_ram.sv
// free_list_ram: DEPTH x WIDTH storage for the free list. One synchronous write port and
// one asynchronous read port. Contents are not reset; the controller rewrites every entry
// after each reset.
module free_list_ram #(
    parameter int unsigned DEPTH = 48,
    parameter int unsigned WIDTH = 6,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rename_free_list.sv
// rename_free_list: physical-register free list for the rename stage. Offers one free preg
// per cycle, takes freed pregs back from commit, and rolls the speculative head back to the
// committed head on a mispredict.
// Build option: FREE_LIST_CHECK_EN enables the sticky consistency checker on error_o;
// without it error_o is tied low.
module rename_free_list
    import Purple_Jade_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  alloc_v_o,
    output logic [PREG_WIDTH-1:0] alloc_preg_o,
    input  logic                  alloc_ready_i,
    input  logic                  commit_alloc_i,
    input  logic                  release_v_i,
    input  logic [PREG_WIDTH-1:0] release_preg_i,
    input  logic                  mispredict_i,
    output logic [CNT_WIDTH-1:0]  free_cnt_o,
    output logic                  error_o
);

    localparam ptr_t LAST_IDX = ptr_t'(FREE_DEPTH - 1);
    localparam cnt_t CNT_FULL = cnt_t'(FREE_DEPTH);

    fl_state_e state_q, state_d;
    ptr_t      init_idx_q, init_idx_d;
    ptr_t      head_q, head_d;
    ptr_t      chead_q, chead_d;
    ptr_t      tail_q, tail_d;
    cnt_t      free_cnt_q, free_cnt_d;
    cnt_t      cfree_cnt_q, cfree_cnt_d;
    logic      alloc_v_q, alloc_v_d;

    logic      ram_we;
    ptr_t      ram_waddr;
    preg_t     ram_wdata;
    preg_t     ram_rdata;

    logic      fire;
    logic      release_ok;
    logic      commit_ok;

    free_list_ram #(
        .DEPTH (FREE_DEPTH),
        .WIDTH (PREG_WIDTH),
        .AW    (PTR_WIDTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (head_q),
        .rdata (ram_rdata)
    );

    // A mispredict discards any fire in the same cycle.
    assign fire = alloc_v_q & alloc_ready_i & ~mispredict_i;

`ifdef FREE_LIST_CHECK_EN
    logic error_q, error_d;
    logic release_bad, commit_bad, ready_bad;

    // Detect illegal operations; offending release/commit are dropped rather than applied.
    always_comb begin
        release_bad = release_v_i && (cfree_cnt_q == CNT_FULL);
        commit_bad  = commit_alloc_i && (chead_q == head_q) && (free_cnt_q == cfree_cnt_q);
        ready_bad   = alloc_ready_i && !alloc_v_q;
        release_ok  = release_v_i && !release_bad;
        commit_ok   = commit_alloc_i && !commit_bad;
        error_d     = error_q;
        if ((state_q != StInit) && (release_bad || commit_bad || ready_bad)) begin
            error_d = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign release_ok = release_v_i;
    assign commit_ok  = commit_alloc_i;
    assign error_o    = 1'b0;
`endif

    // Next-state for the FSM, pointers, counters and the storage write port.
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        head_d      = head_q;
        chead_d     = chead_q;
        tail_d      = tail_q;
        free_cnt_d  = free_cnt_q;
        cfree_cnt_d = cfree_cnt_q;
        ram_we      = 1'b0;
        ram_waddr   = tail_q;
        ram_wdata   = release_preg_i;

        unique case (state_q)
            StInit: begin
                // Seed entry i with preg NUM_ARCH_REGS+i; inputs are ignored here.
                ram_we     = 1'b1;
                ram_waddr  = init_idx_q;
                ram_wdata  = preg_t'(NUM_ARCH_REGS) + preg_t'(init_idx_q);
                init_idx_d = ptr_inc(init_idx_q);
                if (init_idx_q == LAST_IDX) begin
                    state_d     = StRun;
                    init_idx_d  = '0;
                    head_d      = '0;
                    chead_d     = '0;
                    tail_d      = '0;
                    free_cnt_d  = CNT_FULL;
                    cfree_cnt_d = CNT_FULL;
                end
            end
            StRun, StRecover: begin
                ram_we = release_ok;
                if (release_ok) begin
                    tail_d = ptr_inc(tail_q);
                end
                if (commit_ok) begin
                    chead_d = ptr_inc(chead_q);
                end
                cfree_cnt_d = cfree_cnt_q + cnt_t'(release_ok) - cnt_t'(commit_ok);
                if (mispredict_i) begin
                    // Roll back to the committed point after this cycle's commit/release.
                    head_d     = chead_d;
                    free_cnt_d = cfree_cnt_d;
                    state_d    = StRecover;
                end else begin
                    if (fire) begin
                        head_d = ptr_inc(head_q);
                    end
                    free_cnt_d = free_cnt_q + cnt_t'(release_ok) - cnt_t'(fire);
                    state_d    = StRun;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase

        // Offer validity is registered so it never depends on this cycle's inputs.
        alloc_v_d = (state_d == StRun) && (free_cnt_d != '0);
    end

    // FSM, pointer, counter and registered-valid state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StInit;
            init_idx_q  <= '0;
            head_q      <= '0;
            chead_q     <= '0;
            tail_q      <= '0;
            free_cnt_q  <= '0;
            cfree_cnt_q <= '0;
            alloc_v_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            head_q      <= head_d;
            chead_q     <= chead_d;
            tail_q      <= tail_d;
            free_cnt_q  <= free_cnt_d;
            cfree_cnt_q <= cfree_cnt_d;
            alloc_v_q   <= alloc_v_d;
        end
    end

    assign alloc_v_o    = alloc_v_q;
    assign alloc_preg_o = alloc_v_q ? ram_rdata : '0;
    assign free_cnt_o   = free_cnt_q;

endmodule

// File: tb/tb_rename_free_list.sv
// tb_rename_free_list: self-checking bench for rename_free_list. The reference model keeps
// the committed free list as a queue of pregs plus a count of speculative allocations.
module tb_rename_free_list;

    logic       clk_i          = 1'b0;
    logic       reset_i        = 1'b1;
    logic       alloc_v_o;
    logic [5:0] alloc_preg_o;
    logic       alloc_ready_i  = 1'b0;
    logic       commit_alloc_i = 1'b0;
    logic       release_v_i    = 1'b0;
    logic [5:0] release_preg_i = '0;
    logic       mispredict_i   = 1'b0;
    logic [5:0] free_cnt_o;
    logic       error_o;

    int total = 0;
    int bad   = 0;

    // Model: ring holds pregs from the committed head to the tail; k = uncommitted allocs.
    int ring[$];
    int k   = 0;
    int rec = 0;

    typedef struct {
        int rdy;
        int cm;
        int rv;
        int rp;
        int mp;
        int ev;
        int ep;   // -1: offered preg not checked
        int ec;
    } vec_t;

    vec_t tbl[16];

    always #5 clk_i = ~clk_i;

    rename_free_list dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alloc_v_o      (alloc_v_o),
        .alloc_preg_o   (alloc_preg_o),
        .alloc_ready_i  (alloc_ready_i),
        .commit_alloc_i (commit_alloc_i),
        .release_v_i    (release_v_i),
        .release_preg_i (release_preg_i),
        .mispredict_i   (mispredict_i),
        .free_cnt_o     (free_cnt_o),
        .error_o        (error_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_valid();
        return (rec == 0 && ring.size() > k) ? 1 : 0;
    endfunction

    function automatic int m_cnt();
        return ring.size() - k;
    endfunction

    function automatic void m_reset();
        ring.delete();
        for (int i = 0; i < 48; i++) ring.push_back(16 + i);
        k   = 0;
        rec = 0;
    endfunction

    function automatic void m_update(input int rdy, input int cm, input int rv, input int rp,
                                     input int mp);
        int f;
        f = (m_valid() != 0 && rdy != 0 && mp == 0) ? 1 : 0;
        if (rv != 0) ring.push_back(rp);
        if (cm != 0) begin
            void'(ring.pop_front());
            k--;
        end
        if (f != 0) k++;
        if (mp != 0) begin
            k   = 0;
            rec = 1;
        end else begin
            rec = 0;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ":valid"}, int'(alloc_v_o), m_valid());
        chk({tag, ":cnt"}, int'(free_cnt_o), m_cnt());
        if (m_valid() != 0) chk({tag, ":preg"}, int'(alloc_preg_o), ring[k]);
        chk({tag, ":err"}, int'(error_o), 0);
    endtask

    // Called at a negedge: drive inputs, clock once, update model, compare at next negedge.
    task automatic step(input int rdy, input int cm, input int rv, input int rp, input int mp,
                        input string tag);
        alloc_ready_i  = (rdy != 0);
        commit_alloc_i = (cm != 0);
        release_v_i    = (rv != 0);
        release_preg_i = rp[5:0];
        mispredict_i   = (mp != 0);
        @(posedge clk_i);
        m_update(rdy, cm, rv, rp, mp);
        @(negedge clk_i);
        check_model(tag);
    endtask

    // Asynchronous reset mid-cycle, then time the initialisation phase.
    task automatic do_reset(input int rdy);
        int n;
        @(negedge clk_i);
        alloc_ready_i  = (rdy != 0);
        commit_alloc_i = 1'b0;
        release_v_i    = 1'b0;
        mispredict_i   = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("rst_valid", int'(alloc_v_o), 0);
        chk("rst_preg", int'(alloc_preg_o), 0);
        chk("rst_cnt", int'(free_cnt_o), 0);
        chk("rst_err", int'(error_o), 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk_i);
            @(negedge clk_i);
            n++;
            if (alloc_v_o) break;
        end
        chk("init_latency", n, 48);
        chk("init_cnt", int'(free_cnt_o), 48);
        chk("init_preg", int'(alloc_preg_o), 16);
        m_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy, cm, rv, mp;

        // Drain the whole list with ready held high from reset.
        do_reset(1);
        for (int i = 0; i < 48; i++) begin
            step(1, 0, 0, 0, 0, "drain");
            if (i < 47) chk("drain_seq", int'(alloc_preg_o), 17 + i);
        end
        chk("drain_empty_v", int'(alloc_v_o), 0);
        chk("drain_empty_cnt", int'(free_cnt_o), 0);
        for (int i = 0; i < 48; i++) step(0, 1, 0, 0, 0, "commit_all");

        // Release into an empty list: offered the cycle after, not the same cycle.
        release_v_i    = 1'b1;
        release_preg_i = 6'd5;
        #1 chk("rel_not_same", int'(alloc_v_o), 0);
        step(0, 0, 1, 5, 0, "rel5");
        chk("rel5_v", int'(alloc_v_o), 1);
        chk("rel5_preg", int'(alloc_preg_o), 5);
        chk("rel5_cnt", int'(free_cnt_o), 1);

        // Table: 10 fires, 4 commits, mispredict, one recover cycle.
        do_reset(0);
        for (int i = 0; i < 10; i++) tbl[i] = '{1, 0, 0, 0, 0, 1, 17 + i, 47 - i};
        for (int i = 10; i < 14; i++) tbl[i] = '{0, 1, 0, 0, 0, 1, 26, 38};
        tbl[14] = '{0, 0, 0, 0, 1, 0, -1, 44};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 20, 44};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rdy, tbl[i].cm, tbl[i].rv, tbl[i].rp, tbl[i].mp, "tbl");
            chk($sformatf("tbl%0d_v", i), int'(alloc_v_o), tbl[i].ev);
            chk($sformatf("tbl%0d_cnt", i), int'(free_cnt_o), tbl[i].ec);
            if (tbl[i].ep >= 0) chk($sformatf("tbl%0d_preg", i), int'(alloc_preg_o), tbl[i].ep);
        end

        // Fire + release + commit together at free_cnt 30.
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0, "to30");
        chk("pre30_cnt", int'(free_cnt_o), 30);
        chk("pre30_preg", int'(alloc_preg_o), 34);
        step(1, 1, 1, 7, 0, "trio");
        chk("trio_cnt", int'(free_cnt_o), 30);
        chk("trio_preg", int'(alloc_preg_o), 35);

        // Mispredict with a fire and a commit: fire dropped, head = post-commit chead.
        step(1, 1, 0, 0, 1, "misp_fire");
        chk("misp_fire_v", int'(alloc_v_o), 0);
        chk("misp_fire_cnt", int'(free_cnt_o), 43);
        step(0, 0, 0, 0, 0, "post_misp");
        chk("post_misp_v", int'(alloc_v_o), 1);
        chk("post_misp_preg", int'(alloc_preg_o), 22);
        chk("post_misp_cnt", int'(free_cnt_o), 43);

        // The preg released in the trio cycle sits at the old tail, behind pregs 22..63.
        for (int i = 0; i < 42; i++) step(1, 0, 0, 0, 0, "to_tail");
        chk("trio_tail_preg", int'(alloc_preg_o), 7);

        // Random legal traffic against the model, with one reset mid-run.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset(0);
            mp  = ($urandom_range(15) == 0) ? 1 : 0;
            rdy = (m_valid() != 0) ? int'($urandom_range(1)) : 0;
            cm  = (k > 0 && $urandom_range(2) == 0) ? 1 : 0;
            rv  = (ring.size() < 48 && $urandom_range(2) == 0) ? 1 : 0;
            step(rdy, cm, rv, int'($urandom_range(63)), mp, "rand");
        end

`ifdef FREE_LIST_CHECK_EN
        // Overflow release with the list full: error sticks until reset, release dropped.
        do_reset(0);
        release_v_i    = 1'b1;
        release_preg_i = 6'd3;
        @(posedge clk_i);
        @(negedge clk_i);
        release_v_i = 1'b0;
        chk("ovf_err", int'(error_o), 1);
        chk("ovf_cnt", int'(free_cnt_o), 48);
        chk("ovf_preg", int'(alloc_preg_o), 16);
        repeat (3) @(negedge clk_i);
        chk("ovf_sticky", int'(error_o), 1);
        do_reset(0);
`else
        chk("err_tied", int'(error_o), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
